axis_bram_xfer_sched: RTL
=========================

Name: axis_bram_xfer_sched

Overview:
Command-driven scheduler that sequences one axis_bram adapter instance through write (stream->BRAM) and read (BRAM->stream) transfers. It queues transfer commands in a small FIFO and, per command, configures the adapter: direction, address reload and bound index. It gates the adapter's stream handshakes so beats pass only while a transfer runs, tracks line completion, and reports per-transfer status. Sits between the system control plane (DMA/CPU command logic) and the adapter.

Parameters:
BRAM_DEPTH, 12, BRAM address width; line index width.
CMD_FIFO_AW, 2, log2 of command FIFO depth (default 4 entries).
TIMEOUT_CYCLES, 1024, watchdog limit; used only with XFER_TIMEOUT_EN.

Ports:
clk  in  1  clock, all logic on rising edge.
rstn  in  1  reset, synchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full.
cmd_rw  in  1  1 = write to BRAM, 0 = read from BRAM.
cmd_bound  in  BRAM_DEPTH  last line index, inclusive (lines = bound+1).
adp_rw  out  1  adapter direction.
adp_addr_reload  out  1  one-cycle adapter index reset.
adp_bound_index  out  BRAM_DEPTH  bound forwarded to adapter.
adp_bram_en  in  1  adapter BRAM enable; one pulse = one line.
adp_tlast  in  1  adapter stream_out_tlast.
m_axis_tready  in  1  downstream ready (same as adapter stream_out_accep).
s_gate_en  out  1  enables upstream tvalid into adapter.
m_gate_en  out  1  enables adapter tvalid downstream.
busy  out  1  high outside IDLE.
done_valid  out  1  completion status valid.
done_ready  in  1  status consumed.
done_rw  out  1  direction of completed command.
done_lines  out  BRAM_DEPTH+1  lines counted.
done_err  out  1  transfer aborted.

Behaviour:
- Reset (rstn=0 at clk edge): FIFO emptied, state IDLE; all outputs 0 except cmd_ready=1. Reset mid-transfer aborts it with no status; outputs at reset values after that edge.
- FIFO: push on cmd_valid&&cmd_ready; cmd_ready = !full, registered. A pop in the same cycle does not unblock a push when full. Commands are issued in push order.
- States: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: if FIFO non-empty, pop the head, latch rw/bound, go to LOAD.
- LOAD (1 cycle): adp_addr_reload=1, adp_rw and adp_bound_index driven from the latched command; both hold until the next LOAD. Gates low. Line counter cleared. Go to RUN.
- RUN: write -> s_gate_en=1, m_gate_en=0; read -> m_gate_en=1, s_gate_en=0. Line counter (BRAM_DEPTH+1 bits, no wrap) increments on each adp_bram_en=1 cycle.
  Write exits to DRAIN in the cycle count reaches bound+1; s_gate_en drops that same cycle.
  Read exits to DRAIN on adp_tlast&&m_axis_tready; m_gate_en drops the next cycle.
- DRAIN: 2 cycles, gates low, covering the adapter's 2-cycle index-update pipeline. Then go to DONE.
- DONE: done_valid=1, done_rw/done_lines/done_err held stable. On done_ready=1, go to IDLE and drop done_valid the next cycle. No new command starts while done_valid is high.
- Boundary cases:
  bound=0 transfers exactly one line.
  bound=2^BRAM_DEPTH-1 gives done_lines=2^BRAM_DEPTH (extra bit).
  adp_bram_en pulses outside RUN are ignored.
- busy=1 in every state except IDLE.
- Latency: first command pushed into an empty FIFO while IDLE -> adp_addr_reload asserted 2 cycles after the push edge.

Optional Feature:
XFER_TIMEOUT_EN: adds a watchdog counter, cleared on entering RUN and on each adp_bram_en. If it reaches TIMEOUT_CYCLES while in RUN: gates drop, state goes straight to DONE with done_err=1 and done_lines = count so far. Without the macro there is no counter, done_err is tied 0, and RUN waits indefinitely.

Test Plan:
- Write cmd bound=3, stream 4x36 words -> one adp_addr_reload pulse with adp_rw=1; s_gate_en high until the 4th bram_en; done_valid with done_rw=1, done_lines=4, done_err=0.
- Read cmd bound=1, m_axis_tready=1, adapter asserts tlast on the last word -> m_gate_en low the cycle after tlast; done_lines=2, done_rw=0.
- Push 5 cmds back-to-back while the first runs -> cmd_ready low after the 4th queued entry (head popped); completion order matches push order; no command lost.
- Hold done_ready=0 for 20 cycles with a cmd queued -> done_valid stays 1, no adp_addr_reload, outputs stable; done_ready=1 -> next LOAD 2 cycles later.
- Assert rstn=0 mid-RUN of a write with bound=7 -> next cycle gates 0, busy 0, done_valid 0, cmd_ready 1, FIFO empty.
- XFER_TIMEOUT_EN with TIMEOUT_CYCLES=16: write bound=3, stop input after 2 lines -> done_err=1, done_lines=2, 16 cycles after the last bram_en.

Source files
------------

// File: rtl/axis_bram_xfer_sched.sv
// Command-queued scheduler driving one axis_bram adapter through write/read transfers.
// Optional watchdog abort is enabled by defining XFER_TIMEOUT_EN.
module axis_bram_xfer_sched #(
  parameter int BRAM_DEPTH     = 12,
  parameter int CMD_FIFO_AW    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rw,
  input  logic [BRAM_DEPTH-1:0] i_cmd_bound,
  output logic                  o_adp_rw,
  output logic                  o_adp_addr_reload,
  output logic [BRAM_DEPTH-1:0] o_adp_bound_index,
  input  logic                  i_adp_bram_en,
  input  logic                  i_adp_tlast,
  input  logic                  i_m_axis_tready,
  output logic                  o_s_gate_en,
  output logic                  o_m_gate_en,
  output logic                  o_busy,
  output logic                  o_done_valid,
  input  logic                  i_done_ready,
  output logic                  o_done_rw,
  output logic [BRAM_DEPTH:0]   o_done_lines,
  output logic                  o_done_err
);
  localparam int                     FIFO_DEPTH = 1 << CMD_FIFO_AW;
  localparam logic [CMD_FIFO_AW:0]   CNT_FULL   = (CMD_FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [CMD_FIFO_AW:0]   CNT_ZERO   = {(CMD_FIFO_AW+1){1'b0}};
  localparam logic [CMD_FIFO_AW:0]   CNT_ONE    = {{CMD_FIFO_AW{1'b0}}, 1'b1};
  localparam logic [CMD_FIFO_AW-1:0] PTR_ZERO   = {CMD_FIFO_AW{1'b0}};
  localparam logic [CMD_FIFO_AW-1:0] PTR_ONE    = {{(CMD_FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [BRAM_DEPTH:0]    LINES_ZERO = {(BRAM_DEPTH+1){1'b0}};
  localparam logic [BRAM_DEPTH:0]    LINES_ONE  = {{BRAM_DEPTH{1'b0}}, 1'b1};
  localparam logic [BRAM_DEPTH:0]    LINES_MAX  = {(BRAM_DEPTH+1){1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_fifo_rw    [FIFO_DEPTH];
  logic [BRAM_DEPTH-1:0]   r_fifo_bound [FIFO_DEPTH];
  logic [CMD_FIFO_AW-1:0]  r_wr_ptr;
  logic [CMD_FIFO_AW-1:0]  r_rd_ptr;
  logic [CMD_FIFO_AW:0]    r_fifo_cnt;
  logic [CMD_FIFO_AW:0]    w_fifo_cnt_nxt;
  logic                    r_cmd_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    r_rw;
  logic [BRAM_DEPTH-1:0]   r_bound;
  logic [BRAM_DEPTH:0]     r_lines;
  logic                    r_drain;
  logic                    r_err;
  logic                    w_last_line;
  logic                    w_tlast_hs;
  logic                    w_timeout;

  assign w_push      = i_cmd_valid && r_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_fifo_cnt != CNT_ZERO);
  assign w_last_line = i_adp_bram_en && (r_lines == {1'b0, r_bound});
  assign w_tlast_hs  = i_adp_tlast && i_m_axis_tready;
  assign o_cmd_ready = r_cmd_ready;

  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt;
    case ({w_push, w_pop})
      2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + CNT_ONE;
      2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - CNT_ONE;
      default: w_fifo_cnt_nxt = r_fifo_cnt;
    endcase
  end

  // Ready is derived from the post-update count, so a pop never frees a slot in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_fifo_cnt  <= CNT_ZERO;
      r_cmd_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_cmd_ready <= (w_fifo_cnt_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rw[r_wr_ptr]    <= i_cmd_rw;
      r_fifo_bound[r_wr_ptr] <= i_cmd_bound;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rw    <= 1'b0;
      r_bound <= {BRAM_DEPTH{1'b0}};
    end else if (w_pop) begin
      r_rw    <= r_fifo_rw[r_rd_ptr];
      r_bound <= r_fifo_bound[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_lines <= LINES_ZERO;
    end else if (r_state == S_LOAD) begin
      r_lines <= LINES_ZERO;
    end else if ((r_state == S_RUN) && i_adp_bram_en && (r_lines != LINES_MAX)) begin
      r_lines <= r_lines + LINES_ONE;
    end
  end

`ifdef XFER_TIMEOUT_EN
  localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  logic [WDOG_W-1:0] r_wdog;

  // Idle-line watchdog: restarts on every line and whenever the FSM is outside RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else if ((r_state != S_RUN) || i_adp_bram_en) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign w_timeout = (r_state == S_RUN) && !i_adp_bram_en && (r_wdog == WDOG_LAST);
`else
  // No watchdog in this build: a transfer never times out.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_err   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_LOAD;
        else       w_state_nxt = S_IDLE;
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_timeout)                         w_state_nxt = S_DONE;
        else if (r_rw ? w_last_line : w_tlast_hs) w_state_nxt = S_DRAIN;
        else                                   w_state_nxt = S_RUN;
      end
      // Two cycles let the adapter's index-update pipeline settle.
      S_DRAIN: begin
        if (r_drain) w_state_nxt = S_DONE;
        else         w_state_nxt = S_DRAIN;
      end
      S_DONE: begin
        if (i_done_ready) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_adp_rw          = r_rw;
    o_adp_bound_index = r_bound;
    o_adp_addr_reload = 1'b0;
    o_s_gate_en       = 1'b0;
    o_m_gate_en       = 1'b0;
    o_busy            = 1'b1;
    o_done_valid      = 1'b0;
    o_done_rw         = 1'b0;
    o_done_lines      = LINES_ZERO;
    o_done_err        = 1'b0;
    case (r_state)
      S_IDLE:  o_busy = 1'b0;
      S_LOAD:  o_adp_addr_reload = 1'b1;
      S_RUN: begin
        o_s_gate_en = r_rw;
        o_m_gate_en = ~r_rw;
      end
      S_DRAIN: o_busy = 1'b1;
      S_DONE: begin
        o_done_valid = 1'b1;
        o_done_rw    = r_rw;
        o_done_lines = r_lines;
        o_done_err   = r_err;
      end
      default: o_busy = 1'b1;
    endcase
  end

endmodule
